// File: rtl/instruction_fetch_tag_pkg.sv
// Shared I-fetch definitions for the tag stage (IFT) and data stage (IFD).
// Holds the cache geometry, the inter-stage structs and the address-split helpers.
package instruction_fetch_tag_pkg;

  localparam int ICACHE_NUM_WAYS   = 4;
  localparam int ICACHE_NUM_SETS   = 64;
  localparam int ICACHE_LINE_BYTES = 64;
  localparam int SET_W             = $clog2(ICACHE_NUM_SETS);
  localparam int OFF_W             = $clog2(ICACHE_LINE_BYTES);
  localparam int TAG_W             = 32 - SET_W - OFF_W;

  typedef enum logic [0:0] {
    ST_FETCH      = 1'b0,
    ST_INVALIDATE = 1'b1
  } ift_state_e;

  typedef struct packed {
    logic instruction_valid;
  } ift_ctrl_t;

  typedef struct packed {
    logic [31:0]                            fetched_pc;
    logic [ICACHE_NUM_WAYS-1:0]             valid_bits;
    logic [ICACHE_NUM_WAYS-1:0][TAG_W-1:0]  tags_read;
    ift_ctrl_t                              ctrl;
  } ift_ifd_inf_t;

  typedef struct packed {
    logic [ICACHE_NUM_WAYS-1:0] update_tag_en;
    logic [TAG_W-1:0]           update_tag;
    logic [SET_W-1:0]           update_set;
  } ifd_ift_inf_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [SET_W-1:0] get_set(input logic [31:0] addr);
    return addr[OFF_W +: SET_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_tag_tag_array.sv
// Per-way I$ tag RAM plus valid flops: synchronous read, one write port per way,
// write-first forwarding onto the read port, and a whole-set valid clear port.
module icache_tag_array
  import instruction_fetch_tag_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SET_W-1:0]                      rd_set,
  input  logic [ICACHE_NUM_WAYS-1:0]            wr_en,
  input  logic [SET_W-1:0]                      wr_set,
  input  logic [TAG_W-1:0]                      wr_tag,
  input  logic                                  clr_en,
  input  logic [SET_W-1:0]                      clr_set,
  output logic [ICACHE_NUM_WAYS-1:0][TAG_W-1:0] rd_tags,
  output logic [ICACHE_NUM_WAYS-1:0]            rd_valid
);

  logic [TAG_W-1:0]                      tag_mem [ICACHE_NUM_WAYS][ICACHE_NUM_SETS];
  logic [ICACHE_NUM_WAYS-1:0]            valid_q [ICACHE_NUM_SETS];
  logic [ICACHE_NUM_WAYS-1:0][TAG_W-1:0] fwd_tags;
  logic [ICACHE_NUM_WAYS-1:0]            fwd_valid;

  // Tag storage carries no reset; the valid flops alone decide hit eligibility.
  always_ff @(posedge clk) begin
    for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
      if (wr_en[w]) tag_mem[w][wr_set] <= wr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ICACHE_NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      if (clr_en) valid_q[clr_set] <= '0;
      for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
        if (wr_en[w]) valid_q[wr_set][w] <= 1'b1;
      end
    end
  end

  always_comb begin
    fwd_tags  = '0;
    fwd_valid = '0;
    for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
      fwd_tags[w]  = tag_mem[w][rd_set];
      fwd_valid[w] = valid_q[rd_set][w];
      if (clr_en && (clr_set == rd_set)) fwd_valid[w] = 1'b0;
      if (wr_en[w] && (wr_set == rd_set)) begin
        fwd_tags[w]  = wr_tag;
        fwd_valid[w] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_tags  <= '0;
      rd_valid <= '0;
    end else begin
      rd_tags  <= fwd_tags;
      rd_valid <= fwd_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_tag.sv
// I-fetch tag stage: owns the PC, reads I$ tags/valids for the issued address and
// hands {fetched_pc, tags, valids} to IFD one cycle later; runs the fence.i sweep.
module instruction_fetch_tag
  import instruction_fetch_tag_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [31:0]  branch_target,
  input  logic         icache_busy,
  input  logic         invalidate_req,
  output logic         invalidate_done,
  input  ifd_ift_inf_t ifd_ift_inf,
  output ift_ifd_inf_t ift_ifd_inf,
  output ift_state_e   dbg_state
);

  ift_state_e                 state_q, state_d;
  logic [SET_W-1:0]           cnt_q;
  logic [31:0]                pc_q, fetched_pc_q, pend_pc_q, flush_pc;
  logic                       iv_q, done_q, pend_flush_q;
  logic                       accept_inv, sweep_last, advance, clr_en;
  logic [ICACHE_NUM_WAYS-1:0] upd_en;
  logic [SET_W-1:0]           rd_set;

  // fence.i handshake: the requester holds invalidate_req high until it sees the
  // one-cycle invalidate_done pulse; the request is ignored in the pulse cycle so
  // a still-high request cannot restart the sweep.
  assign accept_inv = (state_q == ST_FETCH) && !icache_busy && invalidate_req && !done_q;
  assign sweep_last = (state_q == ST_INVALIDATE) && (cnt_q == SET_W'(ICACHE_NUM_SETS - 1));
  assign flush_pc   = {branch_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:      if (accept_inv) state_d = ST_INVALIDATE;
      ST_INVALIDATE: if (sweep_last) state_d = ST_FETCH;
      default:       state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    advance = (state_q == ST_FETCH) && !stall && !icache_busy && !flush && !accept_inv;
    clr_en  = (state_q == ST_INVALIDATE);
    upd_en  = (state_q == ST_FETCH) ? ifd_ift_inf.update_tag_en : '0;
    // While holding, keep re-reading the presented set so fills show up in place.
    rd_set  = advance ? get_set(pc_q) : get_set(fetched_pc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      fetched_pc_q <= RESET_PC;
      iv_q         <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      pend_flush_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      done_q <= sweep_last;
      cnt_q  <= (state_q == ST_INVALIDATE) ? cnt_q + 1'b1 : '0;
      if (state_q == ST_INVALIDATE) begin
        iv_q <= 1'b0;
        if (sweep_last) begin
          pend_flush_q <= 1'b0;
          if (flush)             pc_q <= flush_pc;
          else if (pend_flush_q) pc_q <= pend_pc_q;
        end else if (flush) begin
          pend_flush_q <= 1'b1;
          pend_pc_q    <= flush_pc;
        end
      end else if (flush) begin
        pc_q <= flush_pc;
        iv_q <= 1'b0;
      end else if (accept_inv) begin
        iv_q <= 1'b0;
      end else if (advance) begin
        fetched_pc_q <= pc_q;
        iv_q         <= 1'b1;
        pc_q         <= pc_q + 32'd4;
      end
    end
  end

  icache_tag_array u_tag_array (
    .clk      (clk),
    .rst      (rst),
    .rd_set   (rd_set),
    .wr_en    (upd_en),
    .wr_set   (ifd_ift_inf.update_set),
    .wr_tag   (ifd_ift_inf.update_tag),
    .clr_en   (clr_en),
    .clr_set  (cnt_q),
    .rd_tags  (ift_ifd_inf.tags_read),
    .rd_valid (ift_ifd_inf.valid_bits)
  );

  assign ift_ifd_inf.fetched_pc             = fetched_pc_q;
  assign ift_ifd_inf.ctrl.instruction_valid = iv_q;
  assign invalidate_done                    = done_q;
  assign dbg_state                          = state_q;

  a_no_update_in_sweep: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_INVALIDATE) |-> (ifd_ift_inf.update_tag_en == '0));

endmodule

// File: tb/tb_instruction_fetch_tag.sv
// Directed bench for instruction_fetch_tag: vector table plus hand-written
// sequences for the fence.i sweep, reset mid-sweep and a PC reference model.
module tb_instruction_fetch_tag;
  import instruction_fetch_tag_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall, flush, icache_busy, invalidate_req, invalidate_done;
  logic [31:0]  branch_target;
  ifd_ift_inf_t upd;
  ift_ifd_inf_t out;
  ift_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_tag #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .branch_target   (branch_target),
    .icache_busy     (icache_busy),
    .invalidate_req  (invalidate_req),
    .invalidate_done (invalidate_done),
    .ifd_ift_inf     (upd),
    .ift_ifd_inf     (out),
    .dbg_state       (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic        busy;
    logic [31:0] target;
    logic [3:0]  upd_en;
    logic [19:0] upd_tag;
    logic [5:0]  upd_set;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic [3:0]  exp_valid;
    int          chk_way;
    logic [19:0] exp_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic f, input logic b, input logic [31:0] t,
                              input logic [3:0] ue, input logic [19:0] ut, input logic [5:0] us,
                              input logic iv, input logic [31:0] pc, input logic [3:0] v,
                              input int cw, input logic [19:0] ct);
    vec_t x;
    x.stall = s; x.flush = f; x.busy = b; x.target = t;
    x.upd_en = ue; x.upd_tag = ut; x.upd_set = us;
    x.exp_iv = iv; x.exp_pc = pc; x.exp_valid = v; x.chk_way = cw; x.exp_tag = ct;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b1; flush = 1'b0; icache_busy = 1'b0; branch_target = '0;
    invalidate_req = 1'b0; upd = '0;
  endtask

  // PC reference model for the random section
  logic [31:0] m_pc, m_fetched;
  logic        m_iv;
  int          done_cnt, inv_cycles, iv_bad, timed_out;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset fetched_pc", 64'(out.fetched_pc), 64'h0);
    check("reset instruction_valid", 64'(out.ctrl.instruction_valid), 64'h0);
    check("reset valid_bits", 64'(out.valid_bits), 64'h0);
    check("reset invalidate_done", 64'(invalidate_done), 64'h0);
    check("reset state", 64'(dbg_state), 64'(ST_FETCH));

    // stall flush busy target upd_en tag set | iv pc valid chk_way tag
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h0, 4'b0000, -1, 0);
    add(1, 0, 0, 0, 4'b0001, 0, 0, 1, 32'h0, 4'b0001, 0, 0);
    for (int k = 1; k < 16; k++) add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'(4 * k), 4'b0001, -1, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h40, 4'b0000, -1, 0);
    add(1, 1, 0, 32'h1003, 4'b0000, 0, 0, 0, 32'h40, 4'b0000, -1, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h1000, 4'b0001, 0, 0);
    add(0, 0, 1, 0, 4'b0000, 0, 0, 1, 32'h1000, 4'b0001, -1, 0);
    add(0, 1, 0, 32'h40, 4'b0000, 0, 0, 0, 32'h1000, 4'b0001, -1, 0);
    add(0, 0, 0, 0, 4'b0100, 20'h5A, 1, 1, 32'h40, 4'b0100, 2, 20'h5A);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h44, 4'b0100, 2, 20'h5A);
    add(0, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 32'h44, 4'b0100, -1, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'hFFFF_FFFC, 4'b0000, -1, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0, 1, 32'h0, 4'b0001, 0, 0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      stall = vecs[i].stall; flush = vecs[i].flush; icache_busy = vecs[i].busy;
      branch_target = vecs[i].target;
      upd.update_tag_en = vecs[i].upd_en;
      upd.update_tag = vecs[i].upd_tag;
      upd.update_set = vecs[i].upd_set;
      step();
      check($sformatf("vec%0d instruction_valid", i), 64'(out.ctrl.instruction_valid), 64'(vecs[i].exp_iv));
      check($sformatf("vec%0d fetched_pc", i), 64'(out.fetched_pc), 64'(vecs[i].exp_pc));
      check($sformatf("vec%0d valid_bits", i), 64'(out.valid_bits), 64'(vecs[i].exp_valid));
      if (vecs[i].chk_way >= 0)
        check($sformatf("vec%0d tags_read", i), 64'(out.tags_read[vecs[i].chk_way]), 64'(vecs[i].exp_tag));
    end

    // fence.i sweep with a flush to 0 landing mid-sweep
    idle_inputs();
    invalidate_req = 1'b1;
    done_cnt = 0; inv_cycles = 0; iv_bad = 0; timed_out = 1;
    for (int c = 0; c < 100; c++) begin
      flush = (c == 10);
      branch_target = 32'h0;
      step();
      if (dbg_state == ST_INVALIDATE) inv_cycles++;
      if (out.ctrl.instruction_valid !== 1'b0) iv_bad++;
      if (invalidate_done === 1'b1) begin
        done_cnt++;
        invalidate_req = 1'b0;
        timed_out = 0;
        break;
      end
    end
    flush = 1'b0;
    check("sweep timeout", 64'(timed_out), 64'h0);
    check("sweep cycles in INVALIDATE", 64'(inv_cycles), 64'd64);
    check("sweep instruction_valid low", 64'(iv_bad), 64'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      if (invalidate_done === 1'b1) done_cnt++;
    end
    check("sweep done pulse count", 64'(done_cnt), 64'd1);
    stall = 1'b0;
    step();
    check("post-sweep fetched_pc", 64'(out.fetched_pc), 64'h0);
    check("post-sweep instruction_valid", 64'(out.ctrl.instruction_valid), 64'h1);
    check("post-sweep valid_bits", 64'(out.valid_bits), 64'h0);

    // random stall/flush/busy against the PC reference model
    m_pc = 32'h4; m_fetched = 32'h0; m_iv = 1'b1;
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      icache_busy = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      branch_target = $urandom_range(0, 32'h0000_FFFF);
      if (flush) begin
        m_pc = {branch_target[31:2], 2'b00};
        m_iv = 1'b0;
      end else if (!stall && !icache_busy) begin
        m_fetched = m_pc;
        m_iv = 1'b1;
        m_pc = m_pc + 32'd4;
      end
      step();
      check($sformatf("rand%0d {iv,fetched_pc}", c),
            {31'h0, out.ctrl.instruction_valid, out.fetched_pc}, {31'h0, m_iv, m_fetched});
    end

    // reset in the middle of a sweep
    idle_inputs();
    stall = 1'b0; flush = 1'b1; branch_target = 32'hC0;
    step();
    flush = 1'b0;
    step();
    stall = 1'b1;
    upd.update_tag_en = 4'b0010; upd.update_tag = 20'h7; upd.update_set = 6'd3;
    step();
    check("set3 fill valid_bits", 64'(out.valid_bits), 64'h2);
    check("set3 fill tags_read", 64'(out.tags_read[1]), 64'h7);
    upd = '0;
    invalidate_req = 1'b1;
    step();
    step();
    check("mid-sweep state", 64'(dbg_state), 64'(ST_INVALIDATE));
    rst = 1'b1;
    invalidate_req = 1'b0;
    #1;
    check("async reset state", 64'(dbg_state), 64'(ST_FETCH));
    check("async reset instruction_valid", 64'(out.ctrl.instruction_valid), 64'h0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (invalidate_done === 1'b1) done_cnt++;
    end
    rst = 1'b0;
    stall = 1'b0;
    step();
    if (invalidate_done === 1'b1) done_cnt++;
    check("after reset fetched_pc", 64'(out.fetched_pc), 64'h0);
    flush = 1'b1; branch_target = 32'hC0;
    step();
    if (invalidate_done === 1'b1) done_cnt++;
    flush = 1'b0;
    step();
    if (invalidate_done === 1'b1) done_cnt++;
    check("after reset set3 fetched_pc", 64'(out.fetched_pc), 64'hC0);
    check("after reset set3 valid_bits", 64'(out.valid_bits), 64'h0);
    check("aborted sweep no done pulse", 64'(done_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
